// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial digit comparator: digit width, FSM states, digit type.
package serial_cmp_pkg;

    localparam int unsigned DIGIT_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } cmp_state_t;

    typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/digit_cascade_cell.sv
// One MSB-first magnitude cascade step: folds a digit pair into the running eq/gt state.
module digit_cascade_cell
    import serial_cmp_pkg::*;
(
    input  digit_t a,
    input  digit_t b,
    input  logic   eq_in,
    input  logic   gt_in,
    output logic   eq_out,
    output logic   gt_out
);

    // A higher digit only counts while all more significant digits were equal.
    always_comb begin
        eq_out = eq_in & (a == b);
        gt_out = gt_in | (eq_in & (a > b));
    end

endmodule

// File: rtl/serial_digit_comparator.sv
// Time-multiplexed magnitude comparator: one digit pair per accepted beat, MSB first,
// one registered eq/gt/lt verdict per operand pair.
module serial_digit_comparator
    import serial_cmp_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIGIT_W-1:0] a_dig,
    input  logic [DIGIT_W-1:0] b_dig,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               eq,
    output logic               gt,
    output logic               lt,
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(DIGITS + 1);
    // cnt holds the number of digits already taken, so the last beat sees DIGITS-1.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    cmp_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             eq_r;
    logic             gt_r;
    logic             seed_eq;
    logic             seed_gt;
    logic             step_eq;
    logic             step_gt;
    logic             accept;
    logic             last_beat;

    assign accept    = in_valid & in_ready;
    assign last_beat = (cnt == LAST_CNT);

    // The MSB beat always starts from "equal so far", regardless of leftover cascade state.
    assign seed_eq = (state == IDLE) ? 1'b1 : eq_r;
    assign seed_gt = (state == IDLE) ? 1'b0 : gt_r;

    digit_cascade_cell u_cell (
        .a      (a_dig),
        .b      (b_dig),
        .eq_in  (seed_eq),
        .gt_in  (seed_gt),
        .eq_out (step_eq),
        .gt_out (step_gt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            eq_r      <= 1'b1;
            gt_r      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE, COLLECT: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        eq_r <= step_eq;
                        gt_r <= step_gt;
                        if (last_beat) begin
                            state     <= DONE;
                            cnt       <= '0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                            eq        <= step_eq;
                            gt        <= step_gt;
                            lt        <= ~step_eq & ~step_gt;
                        end else begin
                            state <= COLLECT;
                            cnt   <= cnt + CNT_W'(1);
                            busy  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        eq_r      <= 1'b1;
                        gt_r      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_digit_comparator.sv
// Directed bench for serial_digit_comparator at DIGITS=4 and an exhaustive sweep at DIGITS=2.
module tb_serial_digit_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] a_dig;
    logic [1:0] b_dig;
    logic       iv4, or4, ir4, ov4, eq4, gt4, lt4, busy4;
    logic       iv2, or2, ir2, ov2, eq2, gt2, lt2, busy2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_digit_comparator #(.DIGITS(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv4),
        .in_ready  (ir4),
        .a_dig     (a_dig),
        .b_dig     (b_dig),
        .out_valid (ov4),
        .out_ready (or4),
        .eq        (eq4),
        .gt        (gt4),
        .lt        (lt4),
        .busy      (busy4)
    );

    serial_digit_comparator #(.DIGITS(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv2),
        .in_ready  (ir2),
        .a_dig     (a_dig),
        .b_dig     (b_dig),
        .out_valid (ov2),
        .out_ready (or2),
        .eq        (eq2),
        .gt        (gt2),
        .lt        (lt2),
        .busy      (busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {out_valid, in_ready, busy, eq, gt, lt}
    function automatic logic [5:0] snap(input bit sel);
        return sel ? {ov2, ir2, busy2, eq2, gt2, lt2} : {ov4, ir4, busy4, eq4, gt4, lt4};
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? ir2 : ir4;
    endfunction

    task automatic set_iv(input bit sel, input logic v);
        if (sel) iv2 = v;
        else     iv4 = v;
    endtask

    task automatic set_or(input bit sel, input logic v);
        if (sel) or2 = v;
        else     or4 = v;
    endtask

    // Presents one digit pair at a falling edge and returns at the falling edge after acceptance.
    task automatic put(input bit sel, input logic [1:0] a, input logic [1:0] b, input int gap);
        int n = 0;
        set_iv(sel, 1'b0);
        repeat (gap) @(negedge clk);
        a_dig = a;
        b_dig = b;
        set_iv(sel, 1'b1);
        while (!rdy(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(0), 32'(1));
        @(negedge clk);
        set_iv(sel, 1'b0);
    endtask

    // exp is {eq, gt, lt}; hold keeps out_ready low that many cycles while junk is offered upstream.
    task automatic get_verdict(input bit sel, input string tag, input logic [2:0] exp, input int hold);
        logic [5:0] s;
        int n = 0;
        s = snap(sel);
        check({tag, "_latency"}, 32'(s[5]), 32'(1));
        while (!s[5] && n < 20) begin
            @(negedge clk);
            n++;
            s = snap(sel);
        end
        check({tag, "_verdict"}, 32'(s[2:0]), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            a_dig = 2'd3;
            b_dig = 2'd0;
            set_iv(sel, 1'b1);
            @(negedge clk);
            s = snap(sel);
            check({tag, "_hold"}, 32'(s), 32'({3'b100, exp}));
        end
        set_or(sel, 1'b1);
        @(negedge clk);
        set_or(sel, 1'b0);
        set_iv(sel, 1'b0);
        s = snap(sel);
        check({tag, "_release"}, 32'(s[5:3]), 32'(3'b010));
    endtask

    task automatic frame(input bit sel, input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] exp, input int gap, input int hold);
        int nd = sel ? 2 : 4;
        for (int i = 0; i < nd; i++) begin
            put(sel, 2'(a >> (2 * (nd - 1 - i))), 2'(b >> (2 * (nd - 1 - i))), (i == 0) ? 0 : gap);
        end
        get_verdict(sel, tag, exp, hold);
    endtask

    // Exactly one verdict bit whenever a verdict is presented.
    always @(negedge clk) begin
        if (ov4) check("onehot4", 32'($countones({eq4, gt4, lt4})), 32'(1));
        if (ov2) check("onehot2", 32'($countones({eq2, gt2, lt2})), 32'(1));
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [2:0] exp;
        rst   = 1'b1;
        iv4   = 1'b0;
        iv2   = 1'b0;
        or4   = 1'b0;
        or2   = 1'b0;
        a_dig = 2'd0;
        b_dig = 2'd0;
        repeat (2) @(negedge clk);
        check("reset4", 32'(snap(1'b0)), 32'(0));
        check("reset2", 32'(snap(1'b1)), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle4", 32'(snap(1'b0)), 32'(6'b010000));
        check("idle2", 32'(snap(1'b1)), 32'(6'b010000));

        frame(1'b0, "t1_eq",  32'hB4, 32'hB4, 3'b100, 0, 0);
        frame(1'b0, "t2_msb", 32'hC0, 32'h3F, 3'b010, 0, 0);
        frame(1'b0, "t3_lt",  32'h54, 32'h55, 3'b001, 0, 0);
        frame(1'b0, "t3_gt",  32'h55, 32'h54, 3'b010, 0, 0);
        frame(1'b0, "t4_bp",  32'h9A, 32'h9B, 3'b001, 2, 5);
        frame(1'b0, "t4_next", 32'h27, 32'h27, 3'b100, 1, 0);

        put(1'b0, 2'd3, 2'd0, 0);
        put(1'b0, 2'd3, 2'd0, 0);
        check("t5_busy", 32'(busy4), 32'(1));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("t5_reset", 32'(snap(1'b0)), 32'(0));
        frame(1'b0, "t5_eq", 32'h12, 32'h12, 3'b100, 0, 0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                exp = (a == b) ? 3'b100 : ((a > b) ? 3'b010 : 3'b001);
                frame(1'b1, $sformatf("t6_%0d_%0d", a, b), 32'(a), 32'(b), exp, 0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_digit_comparator.md
Name: serial_digit_comparator

Overview:
- Sequential magnitude comparator for two unsigned operands of DIGITS x 2 bits each.
- Operands arrive one 2-bit digit pair per accepted beat, most significant digit first.
- The block folds each digit into a running eq/gt cascade state and presents one registered eq/gt/lt verdict per operand pair.
- It sits downstream of the digit-slice operand source and replaces a wide combinational cascade chain with a time-multiplexed one.

Parameters:
- DIGITS, 4, digits per operand (operand width = 2*DIGITS); legal range 1..16.
- DIGIT_W, 2, bits per digit; fixed at 2, exported from the package.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a_dig/b_dig hold a valid digit pair.
- in_ready  out  1  block accepts a digit this cycle.
- a_dig  in  2  current digit of operand A.
- b_dig  in  2  current digit of operand B.
- out_valid  out  1  verdict registers are valid.
- out_ready  in  1  consumer takes the verdict.
- eq  out  1  A == B.
- gt  out  1  A > B.
- lt  out  1  A < B.
- busy  out  1  a frame is in progress (at least one digit accepted, verdict not yet issued).

Behaviour:
- Reset is synchronous, active-high, and applies in every state.
  - Outputs: state=IDLE, in_ready=0, out_valid=0, eq=0, gt=0, lt=0, busy=0, digit counter=0.
  - Internal cascade state: eq_r=1, gt_r=0.
- A digit is accepted when in_valid & in_ready are both high on a rising edge.
- FSM states:
  - IDLE:
    - in_ready=1.
    - The first accepted beat is the MSB digit. It seeds the cascade with eq_in=1, gt_in=0.
    - It sets cnt=1, busy=1, and goes to COLLECT, or to DONE directly if DIGITS==1.
  - COLLECT:
    - in_ready=1.
    - Each accepted beat applies the cascade step and increments cnt.
    - The beat that makes cnt==DIGITS moves to DONE.
    - A cycle with in_valid=0 holds the state (bubbles allowed, no timeout).
  - DONE:
    - in_ready=0, out_valid=1, busy=0.
    - eq=eq_r, gt=gt_r, lt=~eq_r & ~gt_r.
    - out_valid=1 & out_ready=1 returns to IDLE the next cycle and clears out_valid.
    - Outputs hold stable while out_ready=0.
- Cascade step, MSB-first:
  - eq_next = eq_r & (a_dig==b_dig).
  - gt_next = gt_r | (eq_r & (a_dig > b_dig)).
  - Once the comparison is decided, later digits are still consumed but cannot change the verdict.
- Latency: the verdict is valid the cycle after the last digit is accepted. Minimum frame = DIGITS beats + 1 result cycle.
- Throughput: in_ready=0 during DONE, so back-to-back frames lose at least one cycle. No overlap of result and next frame.
- Invariant in DONE: exactly one of eq/gt/lt is 1. The bench checks this every cycle where out_valid=1.
- eq/gt/lt keep their last values outside DONE but are only meaningful while out_valid=1.
- Counter width is $clog2(DIGITS+1). There is no wrap-around, because the counter resets to 0 on frame completion.
- Reset mid-frame discards partial digits. The next accepted beat is treated as an MSB digit.
- Reset while out_valid=1 drops the verdict without a handshake.
- in_valid while in DONE: the beat is not accepted. Upstream must hold it (standard valid/ready; data must stay stable while valid & ~ready).
- out_ready with out_valid=0 has no effect.

Decomposition:
- Package serial_cmp_pkg:
  - DIGIT_W=2.
  - typedef enum logic [1:0] {IDLE, COLLECT, DONE} cmp_state_t.
  - typedef logic [DIGIT_W-1:0] digit_t.
- Sub-module digit_cascade_cell:
  - Purely combinational.
  - Inputs: a, b (digit_t), eq_in, gt_in. Outputs: eq_out, gt_out.
  - Implements the cascade step. It is reused by future parallel comparators.
- The top level holds the FSM, the counter and the eq_r/gt_r registers.

Test Plan:
1. Reset and equal: rst for 2 cycles, then all outputs are 0 and in_ready=0. Next, send A=B=8'hB4 as digits 2,3,1,0 (DIGITS=4), back-to-back, out_ready=1. The cycle after the 4th beat must show out_valid=1, eq=1, gt=0, lt=0.
2. MSB decides: send A=8'hC0 and B=8'h3F, digits (3,0),(0,3),(0,3),(0,3). Response: gt=1, eq=0, lt=0, even though the lower digits favour B.
3. LSB decides: send A=8'h54 and B=8'h55. Response: lt=1. Then send A=8'h55 and B=8'h54. Response: gt=1.
4. Backpressure and bubbles: insert in_valid=0 gaps between digits, and hold out_ready=0 for 5 cycles in DONE. Response: the verdict is unchanged and in_ready=0 throughout DONE. The frame completes after the handshake, and the next frame's first digit is accepted only afterwards.
5. Reset mid-frame: assert rst after 2 digits of A=8'hFF, B=8'h00, then send a full A=B=8'h12 frame. Response: eq=1. The discarded digits must have no influence.
6. Exhaustive sweep at DIGITS=2: run all 16x16 operand pairs through back-to-back frames. Each verdict must match a reference compare, and the one-hot eq/gt/lt check must hold on every out_valid cycle.
